// File: rtl/deserializer_sipo.sv
// -----------------------------------------------------------------------------
// deserializer_sipo
//
// Serial-in, parallel-out UART-style receiver. Recovers LSB-first frames from
// an asynchronous serial line (idle high, one start bit 0, DATA_WIDTH data
// bits, one stop bit 1, every bit CLKS_PER_BIT clocks long), checks framing
// and hands each good word to a one-entry output register.
//
// Parameters
//   DATA_WIDTH    data bits per frame (>= 1)
//   CLKS_PER_BIT  clocks per bit period (even, >= 4)
//
// Ports
//   clk         in   single clock, all state on the rising edge
//   rst         in   asynchronous, active-low reset
//   srl_in      in   serial line, asynchronous to clk, idle high
//   data_ready  in   consumer takes data_out when high together with data_valid
//   data_out    out  last word loaded into the output register
//   data_valid  out  data_out holds a word the consumer has not taken yet
//   frame_err   out  one-cycle pulse: stop bit sampled 0
//   overrun     out  one-cycle pulse: good frame dropped, output register full
//   busy        out  high whenever the receive FSM is not idle
//   dbg_state   out  current FSM state (encoding of state_e), for observation
//
// Output handshake: a word is transferred on every rising edge where
// data_valid and data_ready are both high. data_valid stays high with
// data_out stable until that happens. A new word may be loaded in the same
// cycle the old one is taken. data_ready only feeds registers, so no output
// depends combinationally on it.
// -----------------------------------------------------------------------------
module deserializer_sipo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srl_in,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  // Compare constants, sized to the counters they are compared against.
  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer. Both flops reset to the idle level so that reset does
  // not look like a falling edge on the line.
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= srl_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // ---------------------------------------------------------------------------
  // Receive FSM state
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic                  arm_q,   arm_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [DATA_WIDTH-1:0] sh_q,    sh_d;

  // Shift register contents after pushing rx_s in at the MSB (LSB-first line
  // order means the first bit ends up in bit 0 after DATA_WIDTH shifts).
  logic [DATA_WIDTH-1:0] sh_shifted;

  generate
    if (DATA_WIDTH == 1) begin : g_sh_one
      assign sh_shifted = rx_s;
    end else begin : g_sh_many
      assign sh_shifted = {rx_s, sh_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  // Single-cycle strobes produced at the stop-bit sample point.
  logic frame_good;
  logic frame_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arm_d      = arm_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // The arm flag requires the line to have been seen high before a
        // falling edge is accepted, so a line stuck low after a framing error
        // (break) does not produce a stream of bogus frames.
        if (rx_s) begin
          arm_d = 1'b1;
        end else if (arm_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF_M1) begin
          // Middle of the start bit: still low means a real start bit and
          // every following sample lands mid-bit. High means a glitch.
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = sh_shifted;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s) begin
            frame_good = 1'b1;
            arm_d      = 1'b1;
          end else begin
            frame_bad = 1'b1;
            arm_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One-entry output register and status pulses
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_err_q,  frame_err_d;
  logic                  overrun_q,    overrun_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    // frame_good and frame_bad are mutually exclusive, so frame_err and
    // overrun can never be high together.
    frame_err_d  = frame_bad;
    overrun_d    = 1'b0;

    if (frame_good) begin
      // The register is free if empty or being emptied on this same edge.
      if (!data_valid_q || data_ready) begin
        data_out_d   = sh_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_deserializer_sipo.sv
module tb_deserializer_sipo;

  localparam int DW        = 8;
  localparam int CPB       = 16;
  // Stop-sample edge relative to t0: 2 (sync) + 8 (half bit) + 9*16.
  localparam int STOP_OFS  = 154;
  // Busy-fall edge after a rejected glitch: 2 + 8.
  localparam int GLITCH_OFS = 10;
  // Length of one frame on the line: 10 bits * 16 clocks.
  localparam int FRAME_CYC = 160;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic          srl_in;
  logic          data_ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;
  logic [1:0]    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  deserializer_sipo #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .srl_in     (srl_in),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int cyc     = 0;
  int checks  = 0;
  int errors  = 0;
  int last_t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- event monitor ----------------
  // Records the edge number at which each pulse / rising edge is seen.
  int   ferr_q[$];
  int   ovr_q[$];
  int   rise_q[$];
  int   brise_q[$];
  int   bfall_q[$];
  logic dv_prev   = 1'b0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      dv_prev   <= 1'b0;
      busy_prev <= 1'b0;
    end else begin
      if (frame_err) ferr_q.push_back(cyc);
      if (overrun)   ovr_q.push_back(cyc);
      if (data_valid && !dv_prev) rise_q.push_back(cyc);
      if (busy && !busy_prev)     brise_q.push_back(cyc);
      if (!busy && busy_prev)     bfall_q.push_back(cyc);
      if (frame_err || overrun) begin
        checks++;
        if (frame_err && overrun) begin
          errors++;
          $display("FAIL pulse_exclusive: frame_err and overrun both high at edge %0d", cyc);
        end
      end
      dv_prev   <= data_valid;
      busy_prev <= busy;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick(1);
  endtask

  task automatic drive_bit(input logic b);
    srl_in = b;
    tick(CPB);
  endtask

  // Sends one frame; t0 is the next edge, where sync flop 1 captures the start bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    last_t0 = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(stop);
    srl_in = 1'b1;
  endtask

  task automatic clear_q();
    ferr_q.delete();
    ovr_q.delete();
    rise_q.delete();
    brise_q.delete();
    bfall_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    logic          ready;
    logic          exp_dv;
    logic [DW-1:0] exp_dout;
    int            exp_ferr;
    int            exp_ovr;
    int            exp_rise;
  } vec_t;

  vec_t vecs[6];

  int t1;
  int t2;
  int tf;
  logic busy_bad;

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, ready: 1'b0, exp_dv: 1'b1, exp_dout: 8'hA5, exp_ferr: 0, exp_ovr: 0, exp_rise: 1};
    vecs[1] = '{data: 8'h3C, stop: 1'b1, ready: 1'b0, exp_dv: 1'b1, exp_dout: 8'h3C, exp_ferr: 0, exp_ovr: 0, exp_rise: 1};
    vecs[2] = '{data: 8'h5A, stop: 1'b0, ready: 1'b0, exp_dv: 1'b0, exp_dout: 8'h3C, exp_ferr: 1, exp_ovr: 0, exp_rise: 0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, ready: 1'b1, exp_dv: 1'b0, exp_dout: 8'hFF, exp_ferr: 0, exp_ovr: 0, exp_rise: 1};
    vecs[4] = '{data: 8'h00, stop: 1'b1, ready: 1'b0, exp_dv: 1'b1, exp_dout: 8'h00, exp_ferr: 0, exp_ovr: 0, exp_rise: 1};
    vecs[5] = '{data: 8'h81, stop: 1'b0, ready: 1'b0, exp_dv: 1'b0, exp_dout: 8'h00, exp_ferr: 1, exp_ovr: 0, exp_rise: 0};

    // ---- reset ----
    rst        = 1'b0;
    srl_in     = 1'b1;
    data_ready = 1'b0;
    tick(3);
    chk("reset data_out",   data_out,   '0);
    chk("reset data_valid", data_valid, 1'b0);
    chk("reset frame_err",  frame_err,  1'b0);
    chk("reset overrun",    overrun,    1'b0);
    chk("reset busy",       busy,       1'b0);
    rst = 1'b1;
    tick(5);

    // ---- table-driven single frames, output drained after each ----
    for (int i = 0; i < 6; i++) begin
      clear_q();
      data_ready = vecs[i].ready;
      send_frame(vecs[i].data, vecs[i].stop);
      tick(10);
      chk($sformatf("v%0d data_valid", i), data_valid, vecs[i].exp_dv);
      chk($sformatf("v%0d data_out", i), data_out, vecs[i].exp_dout);
      chk($sformatf("v%0d frame_err count", i), ferr_q.size(), vecs[i].exp_ferr);
      chk($sformatf("v%0d overrun count", i), ovr_q.size(), vecs[i].exp_ovr);
      chk($sformatf("v%0d valid rise count", i), rise_q.size(), vecs[i].exp_rise);
      if (vecs[i].exp_ferr > 0)
        chk($sformatf("v%0d frame_err edge", i), (ferr_q.size() > 0) ? ferr_q[0] : -1, last_t0 + STOP_OFS);
      if (vecs[i].exp_rise > 0)
        chk($sformatf("v%0d valid rise edge", i), (rise_q.size() > 0) ? rise_q[0] : -1, last_t0 + STOP_OFS);
      data_ready = 1'b1;
      tick(1);
      data_ready = 1'b0;
      chk($sformatf("v%0d drained", i), data_valid, 1'b0);
    end

    // ---- 0xA5 held until data_ready, clears on the following edge ----
    clear_q();
    send_frame(8'hA5, 1'b1);
    tick(30);
    chk("hold valid", data_valid, 1'b1);
    chk("hold data_out", data_out, 8'hA5);
    data_ready = 1'b1;
    @(negedge clk);
    chk("hold valid before edge", data_valid, 1'b1);
    @(posedge clk);
    #1;
    chk("hold valid after edge", data_valid, 1'b0);
    chk("hold data_out retained", data_out, 8'hA5);
    data_ready = 1'b0;
    tick(5);

    // ---- start glitch: line low 4 cycles ----
    clear_q();
    last_t0 = cyc + 1;
    srl_in = 1'b0;
    tick(4);
    srl_in = 1'b1;
    tick(30);
    chk("glitch busy rises", brise_q.size(), 1);
    chk("glitch busy rise edge", (brise_q.size() > 0) ? brise_q[0] : -1, last_t0 + 2);
    chk("glitch busy fall edge", (bfall_q.size() > 0) ? bfall_q[0] : -1, last_t0 + GLITCH_OFS);
    chk("glitch no frame_err", ferr_q.size(), 0);
    chk("glitch no valid", rise_q.size(), 0);
    chk("glitch idle", busy, 1'b0);

    // ---- bad stop bit, line held low (break) ----
    clear_q();
    send_frame(8'h5A, 1'b0);
    srl_in   = 1'b0;
    busy_bad = 1'b0;
    repeat (40) begin
      tick(1);
      if (busy) busy_bad = 1'b1;
    end
    chk("break frame_err count", ferr_q.size(), 1);
    chk("break frame_err edge", (ferr_q.size() > 0) ? ferr_q[0] : -1, last_t0 + STOP_OFS);
    chk("break busy stayed low", busy_bad, 1'b0);
    chk("break no valid", rise_q.size(), 0);
    srl_in = 1'b1;
    tick(10);
    send_frame(8'h33, 1'b1);
    tick(10);
    chk("after break valid", data_valid, 1'b1);
    chk("after break data_out", data_out, 8'h33);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    tick(5);

    // ---- back-to-back 0x3C, 0xC3 with data_ready low: overrun ----
    clear_q();
    t1 = cyc + 1;
    t2 = t1 + FRAME_CYC;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    tick(10);
    chk("ovr count", ovr_q.size(), 1);
    chk("ovr edge", (ovr_q.size() > 0) ? ovr_q[0] : -1, t2 + STOP_OFS);
    chk("ovr data_out kept", data_out, 8'h3C);
    chk("ovr valid", data_valid, 1'b1);
    chk("ovr no frame_err", ferr_q.size(), 0);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    chk("ovr drained", data_valid, 1'b0);
    tick(5);

    // ---- back-to-back 0x01, 0xFF, data_ready only on second stop sample ----
    clear_q();
    t1 = cyc + 1;
    t2 = t1 + FRAME_CYC;
    fork
      begin
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        wait_cyc(t2 + STOP_OFS - 1);
        data_ready = 1'b1;
        wait_cyc(t2 + STOP_OFS);
        data_ready = 1'b0;
      end
    join
    tick(10);
    chk("swap no overrun", ovr_q.size(), 0);
    chk("swap data_out", data_out, 8'hFF);
    chk("swap valid", data_valid, 1'b1);
    chk("swap single rise", rise_q.size(), 1);
    chk("swap rise edge", (rise_q.size() > 0) ? rise_q[0] : -1, t1 + STOP_OFS);

    // ---- reset mid-frame, then 0x81 ----
    tf = cyc + 1;
    fork
      send_frame(8'hFC, 1'b1);
      begin
        wait_cyc(tf + 60);
        rst = 1'b0;
        #1;
        chk("midrst data_valid", data_valid, 1'b0);
        chk("midrst data_out", data_out, '0);
        chk("midrst busy", busy, 1'b0);
        tick(3);
        rst = 1'b1;
        clear_q();
      end
    join
    tick(10);
    chk("aborted no valid", rise_q.size(), 0);
    chk("aborted no frame_err", ferr_q.size(), 0);
    clear_q();
    send_frame(8'h81, 1'b1);
    tick(10);
    chk("post rst valid", data_valid, 1'b1);
    chk("post rst data_out", data_out, 8'h81);
    chk("post rst rise edge", (rise_q.size() > 0) ? rise_q[0] : -1, last_t0 + STOP_OFS);
    chk("post rst no frame_err", ferr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
